// File: rtl/spdif_pkg.sv
// Shared S/PDIF timing constants and scheduler state encoding.
// The frame assembler imports the same subframe/frame lengths from here.
package spdif_pkg;

   localparam int SUBFRAME_CLKS = 64;
   localparam int FRAME_CLKS    = 128;
   localparam int SAMPLE_W      = 20;
   localparam int FRAME_TOL     = 4;

   typedef enum logic [1:0] {IDLE, PREFILL, RUN} sched_state_t;

endpackage

// File: rtl/stereo_pair_fifo.sv
// Synchronous FIFO of stereo pairs with registered read data and exact occupancy.
// A pop on empty loads zero into the read register so the consumer emits silence.
module stereo_pair_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   assign full    = level == (AW+1)'(DEPTH);
   assign empty   = level == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         rdata <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         if (pop)     rdata <= do_pop ? mem[rptr] : '0;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/spdif_tx_scheduler.sv
// Buffers stereo pairs and paces the S/PDIF frame assembler: prefill gating,
// per-frame pop with left/right switch at the subframe boundary, underrun and timing checks.
module spdif_tx_scheduler #(
   parameter int SAMPLE_W     = spdif_pkg::SAMPLE_W,
   parameter int DEPTH        = 16,
   parameter int PREFILL      = 8,
   parameter int MAX_UNDERRUN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [SAMPLE_W-1:0]     in_left,
   input  logic [SAMPLE_W-1:0]     in_right,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    frame_ready,
   output logic [SAMPLE_W-1:0]     din,
   output logic                    fifo_ready,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    underrun,
   output logic                    frame_err,
   input  logic                    clear_status
);
   import spdif_pkg::*;

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(FRAME_CLKS);
   localparam int UW = $clog2(MAX_UNDERRUN + 1);
   localparam logic [OW-1:0] OFF_HALF    = OW'(SUBFRAME_CLKS - 1);
   localparam logic [OW-1:0] OFF_LAST    = OW'(FRAME_CLKS - 1);
   localparam logic [2:0]    TMO_ON_TIME = 3'd1;
   localparam logic [2:0]    TMO_EXPIRE  = 3'(FRAME_TOL);
   localparam logic [2:0]    TMO_SAT     = 3'(FRAME_TOL + 1);
   localparam logic [UW-1:0] EMPTY_LAST  = UW'(MAX_UNDERRUN - 1);
   localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);
   localparam sched_state_t  ST_PREFILL  = spdif_pkg::PREFILL;

   sched_state_t            state;
   logic [OW-1:0]           offset;
   logic [2:0]              tmo;
   logic [UW-1:0]           empties;
   logic                    armed, second_half;
   logic                    push, pop, full, empty;
   logic                    underrun_set, frame_err_set;
   logic [2*SAMPLE_W-1:0]   pair;

   assign in_ready     = enable && state != IDLE && !full;
   assign push         = in_valid && in_ready;
   assign pop          = enable && state == RUN && frame_ready;
   assign underrun_set = pop && empty;
   assign din          = second_half ? pair[SAMPLE_W-1:0] : pair[2*SAMPLE_W-1:SAMPLE_W];

   // tmo counts cycles spent at offset 127: an on-time pulse lands exactly one cycle in.
   always_comb begin
      frame_err_set = 1'b0;
      if (enable && state == RUN && armed)
         frame_err_set = frame_ready ? (tmo != TMO_ON_TIME) : (tmo == TMO_EXPIRE);
   end

   stereo_pair_fifo #(.WIDTH(2*SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (!enable),
      .wdata ({in_left, in_right}),
      .rdata (pair),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fifo_ready  <= 1'b0;
         offset      <= '0;
         tmo         <= '0;
         empties     <= '0;
         armed       <= 1'b0;
         second_half <= 1'b0;
         underrun    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (underrun_set)       underrun <= 1'b1;
         else if (clear_status)  underrun <= 1'b0;
         if (frame_err_set)      frame_err <= 1'b1;
         else if (clear_status)  frame_err <= 1'b0;

         if (!enable) begin
            state       <= IDLE;
            fifo_ready  <= 1'b0;
            offset      <= '0;
            tmo         <= '0;
            empties     <= '0;
            armed       <= 1'b0;
            second_half <= 1'b0;
         end else begin
            case (state)
               IDLE: state <= ST_PREFILL;
               ST_PREFILL: begin
                  if (level >= PREFILL_LVL) begin
                     state      <= RUN;
                     fifo_ready <= 1'b1;
                  end
               end
               RUN: begin
                  if (frame_ready) begin
                     armed       <= 1'b1;
                     offset      <= OW'(1);
                     tmo         <= '0;
                     second_half <= 1'b0;
                     if (!empty) begin
                        empties <= '0;
                     end else if (empties == EMPTY_LAST) begin
                        // Starved too long: stop the assembler and refill, keeping buffered data.
                        state      <= ST_PREFILL;
                        fifo_ready <= 1'b0;
                        empties    <= '0;
                        armed      <= 1'b0;
                     end else begin
                        empties <= empties + 1'b1;
                     end
                  end else begin
                     if (offset != OFF_LAST)   offset <= offset + 1'b1;
                     else if (tmo != TMO_SAT)  tmo <= tmo + 3'd1;
                     if (offset == OFF_HALF)   second_half <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spdif_tx_scheduler.sv
// Directed bench for spdif_tx_scheduler: a cycle-level queue model checked every cycle,
// plus literal expectations at the points the plan calls out.
module tb_spdif_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [19:0] in_left = '0, in_right = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        frame_ready = 1'b0;
   logic [19:0] din;
   logic        fifo_ready;
   logic [4:0]  level;
   logic        underrun, frame_err;
   logic        clear_status = 1'b0;

   int total = 0;
   int bad = 0;

   spdif_tx_scheduler dut (
      .clk(clk), .rst(rst), .enable(enable),
      .in_left(in_left), .in_right(in_right), .in_valid(in_valid), .in_ready(in_ready),
      .frame_ready(frame_ready), .din(din), .fifo_ready(fifo_ready), .level(level),
      .underrun(underrun), .frame_err(frame_err), .clear_status(clear_status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 filling, 2 running. Times are absolute cycle numbers.
   logic [39:0] q[$];
   int   mode = 0;
   int   cyc = 0;
   int   tp = 0;
   int   ucnt = 0;
   bit   armed = 0;
   logic m_fr = 0, m_uf = 0, m_fe = 0;
   logic [19:0] pl = '0, pr = '0;

   always @(posedge clk) begin
      bit su, sf, acc;
      logic [39:0] w;
      su = 0; sf = 0;
      if (rst) begin
         q.delete(); mode = 0; m_fr = 0; m_uf = 0; m_fe = 0;
         pl = '0; pr = '0; tp = 0; ucnt = 0; armed = 0;
      end else begin
         acc = in_valid && enable && mode != 0 && q.size() < 16;
         if (!enable) begin
            mode = 0; q.delete(); m_fr = 0; pl = '0; pr = '0; ucnt = 0; armed = 0;
         end else if (mode == 0) begin
            mode = 1;
         end else if (mode == 1) begin
            if (q.size() >= 8) begin mode = 2; m_fr = 1; end
         end else if (frame_ready) begin
            if (armed && cyc - tp != 128) sf = 1;
            armed = 1; tp = cyc;
            if (q.size() == 0) begin
               pl = '0; pr = '0; su = 1; ucnt++;
               if (ucnt == 4) begin mode = 1; m_fr = 0; ucnt = 0; armed = 0; end
            end else begin
               w = q.pop_front(); pl = w[39:20]; pr = w[19:0]; ucnt = 0;
            end
         end else if (armed && cyc - tp == 131) begin
            sf = 1;
         end
         if (acc) q.push_back({in_left, in_right});
         m_uf = su ? 1'b1 : (clear_status ? 1'b0 : m_uf);
         m_fe = sf ? 1'b1 : (clear_status ? 1'b0 : m_fe);
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("fifo_ready", fifo_ready, m_fr);
         chk("level", level, q.size());
         chk("in_ready", in_ready, enable && mode != 0 && q.size() < 16);
         chk("din", din, (cyc - tp >= 64) ? pr : pl);
         chk("underrun", underrun, m_uf);
         chk("frame_err", frame_err, m_fe);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_pair(input logic [19:0] l, input logic [19:0] r);
      int n = 0;
      in_left = l; in_right = r; in_valid = 1'b1;
      while (!in_ready && n < 300) begin tick(); n++; end
      chk("push_accept", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pulse_gap(input int gap);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      repeat (gap - 1) tick();
   endtask

   // Pulse, then pin left/right on din at the subframe edges of a 128-clock frame.
   task automatic pulse_chk(input logic [19:0] l, input logic [19:0] r);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk("din_t1", din, l);
      repeat (62) tick(); chk("din_t63", din, l);
      tick();             chk("din_t64", din, r);
      repeat (64) tick(); chk("din_t128", din, r);
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_fifo_ready", fifo_ready, 0);
      chk("rst_level", level, 0);
      chk("rst_din", din, 0);
      chk("rst_flags", {underrun, frame_err, in_ready}, 0);

      // Prefill, then fill to capacity
      enable = 1'b1;
      for (int i = 1; i <= 8; i++) push_pair(20'(i), 20'h80000 | 20'(i));
      chk("pre_level8", level, 8);
      chk("pre_fr_low", fifo_ready, 0);
      tick();
      chk("pre_fr_high", fifo_ready, 1);
      chk("pre_din", din, 0);
      for (int i = 0; i < 8; i++) push_pair(20'h12345, 20'hABCDE);
      chk("full_level", level, 16);
      chk("full_in_ready", in_ready, 0);
      in_left = 20'hFFFFF; in_right = 20'hFFFFF; in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("full_no_17th", level, 16);

      // Steady run, one pulse per 128 clocks drains all 16 pairs
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk("pop_in_ready", in_ready, 1);
      chk("pop_level", level, 15);
      chk("pop_din_l1", din, 20'h00001);
      repeat (127) tick();
      for (int p = 2; p <= 16; p++) begin
         if (p == 2)      pulse_chk(20'h00002, 20'h80002);
         else if (p == 9) pulse_chk(20'h12345, 20'hABCDE);
         else             pulse_gap(128);
      end
      chk("run_level0", level, 0);
      chk("run_no_ferr", frame_err, 0);
      chk("run_no_uflow", underrun, 0);

      // Underrun: four empty pops stop the assembler
      pulse_gap(128);
      chk("uf_flag", underrun, 1);
      chk("uf_din0", din, 0);
      chk("uf_still_run", fifo_ready, 1);
      pulse_gap(128);
      pulse_gap(128);
      pulse_gap(1);
      chk("uf_stop", fifo_ready, 0);
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      chk("uf_clear", underrun, 0);
      for (int i = 0; i < 8; i++) push_pair(20'h00100 + 20'(i), 20'h00200 + 20'(i));
      tick();
      chk("uf_refill", fifo_ready, 1);

      // Frame timing: short spacing (with a simultaneous clear), then a missing pulse
      pulse_gap(100);
      frame_ready = 1'b1; clear_status = 1'b1; tick();
      frame_ready = 1'b0; clear_status = 1'b0;
      chk("ferr_short", frame_err, 1);
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      chk("ferr_clear", frame_err, 0);
      repeat (138) tick();
      chk("ferr_timeout", frame_err, 1);
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      chk("ferr_clear2", frame_err, 0);

      // Disable mid-frame, then restart from empty
      pulse_gap(30);
      enable = 1'b0; tick();
      chk("dis_fr", fifo_ready, 0);
      chk("dis_din", din, 0);
      chk("dis_level", level, 0);
      chk("dis_in_ready", in_ready, 0);
      enable = 1'b1;
      for (int i = 0; i < 8; i++) push_pair(20'h00300 + 20'(i), 20'h00400 + 20'(i));
      tick();
      chk("reen_fr", fifo_ready, 1);
      chk("reen_level", level, 8);
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spdif_tx_scheduler.md
Name: spdif_tx_scheduler

Overview:
- Feeds stereo 20-bit PCM pairs to the S/PDIF frame assembler (`frame_assembly`) and decides when it runs.
- Buffers incoming pairs and holds the assembler idle (`fifo_ready` low) until a prefill level is reached.
- On each assembler `frame_ready` pulse, pops one pair and presents left on `din` for subframe A, then right for subframe B at the 64-clock subframe boundary.
- Handles underrun, enable/disable and frame-timing checks.

Parameters:
- SAMPLE_W, 20, audio sample width (matches assembler `din`).
- DEPTH, 16, stereo-pair buffer entries (power of 2, ≥4).
- PREFILL, 8, occupancy required before `fifo_ready` asserts (1..DEPTH).
- MAX_UNDERRUN, 4, consecutive empty pops before the assembler is stopped and prefill restarts.

Ports:
- clk  in  1  assembler bit clock (6.144 MHz)
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request; low = stop and flush
- in_left  in  SAMPLE_W  left sample
- in_right  in  SAMPLE_W  right sample
- in_valid  in  1  pair valid
- in_ready  out  1  pair accepted when in_valid && in_ready
- frame_ready  in  1  1-cycle frame-request pulse from assembler
- din  out  SAMPLE_W  sample to assembler
- fifo_ready  out  1  assembler run enable (low holds assembler in reset)
- level  out  $clog2(DEPTH)+1  buffer occupancy
- underrun  out  1  sticky: a pop found the buffer empty
- frame_err  out  1  sticky: frame_ready spacing ≠ 128 clocks
- clear_status  in  1  clears underrun and frame_err

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer empty, counters 0.
- Clock/reset: one clock domain; synchronous active-high reset on `rst`, with priority over everything.
- `in_ready` = enable && state≠IDLE && !full, from the registered count (no combinational path from pop).
- Push and pop in the same cycle: net level unchanged.
- Pop on empty is an underrun; there is no bypass from push.
- States:
  - IDLE: pointers/count held at 0; `fifo_ready`=0; `din`=0. enable=1 → PREFILL.
  - PREFILL: accept pushes. When level≥PREFILL → RUN and `fifo_ready`<=1 (visible next cycle). `din`=0.
  - RUN: `fifo_ready`=1.
    - On a frame_ready pulse at cycle t0: pop one pair into a pair register (left and right); `din`=left from t0+1.
    - Subframe offset counter: set to 1 at t0, increments to 127, then saturates.
    - When offset==63, `din`<=right, visible from t0+64 to the next pulse.
- Pop on empty: pair register <= 0; `underrun` set; consecutive-empty counter +1.
- A successful pop resets the consecutive-empty counter.
- Counter reaching MAX_UNDERRUN: `fifo_ready`<=0, state PREFILL, `din`<=0. The buffer is not flushed.
- Frame check in RUN:
  - The first pulse after entering RUN is unchecked.
  - Any later pulse with offset≠127 at arrival (spacing ≠128 clocks) sets `frame_err`.
  - No pulse by offset 127 + 4 clocks also sets `frame_err`; the offset counter saturates and a separate 3-bit timeout counter extends the window.
  - The pair is still popped on an early pulse.
- enable=0 in any state: next cycle `fifo_ready`=0, `din`=0, buffer flushed (level=0), state IDLE. In-flight pair discarded.
- clear_status: clears the sticky flags the next cycle. A simultaneous set event wins.
- Occupancy `level` is registered and exact: 0..DEPTH. Pointers wrap modulo DEPTH.

Decomposition:
- Package `spdif_pkg`: SUBFRAME_CLKS=64, FRAME_CLKS=128, SAMPLE_W=20, FRAME_TOL=4, enum sched_state_t {IDLE, PREFILL, RUN}.
- `frame_assembly` should import SUBFRAME_CLKS/FRAME_CLKS from the same package.
- Sub-module `stereo_pair_fifo`:
  - Synchronous FIFO of 2×SAMPLE_W words, DEPTH entries.
  - Ports: push, pop, flush, full, empty, level.
  - Registered read data; read data valid the cycle after pop.

Test Plan:
- Prefill: enable=1; push 8 pairs (L=0x0000N, R=0x8000N), no pulses → `fifo_ready` rises exactly 1 cycle after the 8th push is accepted; `level`=8; `din`=0.
- Steady run: pulse every 128 clks with pairs L=0x12345/R=0xABCDE → `din`=0x12345 on t0+1..t0+63, 0xABCDE on t0+64..t0+128; `level` decrements per pulse; no flags.
- Full: push 16 pairs with no pops → `in_ready`=0 at level 16; a 17th pair is not accepted. One pulse then re-raises `in_ready` the next cycle.
- Underrun: stop pushing and drain → first empty pop gives `din`=0 and `underrun`=1. The 4th consecutive empty pop drops `fifo_ready` (state PREFILL). Eight new pushes re-raise it.
- Timing error: pulse at spacing 100, then no pulse for 140 clks → `frame_err`=1 on both; `clear_status` clears it next cycle.
- Disable mid-frame: enable=0 at t0+30 → next cycle `fifo_ready`=0, `din`=0, `level`=0, `in_ready`=0. Re-enable → PREFILL behaviour repeats from empty.
